// File: rtl/dpram_port_arbiter.sv
// Maps four requesters onto the two ports of a synchronous dual-port RAM with
// round-robin priority, same-address hazard avoidance and fixed read latency.
module dpram_port_arbiter #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [3:0]      req_i,
    input  logic [3:0]      we_i,
    input  logic [4*AW-1:0] addr_i,
    input  logic [4*DW-1:0] wdata_i,
    output logic [3:0]      gnt_o,
    output logic [3:0]      rvalid_o,
    output logic [4*DW-1:0] rdata_o,
    output logic            ram_we_a,
    output logic [AW-1:0]   ram_addr_a,
    output logic [DW-1:0]   ram_din_a,
    output logic            ram_we_b,
    output logic [AW-1:0]   ram_addr_b,
    output logic [DW-1:0]   ram_din_b,
    input  logic [DW-1:0]   ram_dout_a,
    input  logic [DW-1:0]   ram_dout_b
);

    logic [1:0]    ptr;
    logic [AW-1:0] addr_arr  [4];
    logic [DW-1:0] wdata_arr [4];
    logic [DW-1:0] rdata_q   [4];
    logic          a_found, b_found;
    logic [1:0]    a_idx, b_idx, scan_idx;
    logic          s1_vld_a, s1_vld_b, s2_vld_a, s2_vld_b;
    logic [1:0]    s1_tag_a, s1_tag_b, s2_tag_a, s2_tag_b;

    for (genvar g = 0; g < 4; g++) begin : g_unpack
        assign addr_arr[g]         = addr_i[g*AW +: AW];
        assign wdata_arr[g]        = wdata_i[g*DW +: DW];
        assign rdata_o[g*DW +: DW] = rdata_q[g];
    end

    // Port B skips any requester touching port A's address unless both only read.
    always_comb begin
        a_found  = 1'b0;
        b_found  = 1'b0;
        a_idx    = '0;
        b_idx    = '0;
        scan_idx = '0;
        for (int k = 0; k < 4; k++) begin
            scan_idx = ptr + 2'(k);
            if (req_i[scan_idx]) begin
                if (!a_found) begin
                    a_found = 1'b1;
                    a_idx   = scan_idx;
                end else if (!b_found &&
                             !((addr_arr[scan_idx] == addr_arr[a_idx]) &&
                               (we_i[scan_idx] || we_i[a_idx]))) begin
                    b_found = 1'b1;
                    b_idx   = scan_idx;
                end
            end
        end
    end

    always_comb begin
        gnt_o = '0;
        if (rst_n && a_found) gnt_o[a_idx] = 1'b1;
        if (rst_n && b_found) gnt_o[b_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr        <= '0;
            ram_we_a   <= 1'b0;
            ram_addr_a <= '0;
            ram_din_a  <= '0;
            ram_we_b   <= 1'b0;
            ram_addr_b <= '0;
            ram_din_b  <= '0;
        end else begin
            if (b_found)
                ptr <= b_idx + 2'd1;
            else if (a_found)
                ptr <= a_idx + 2'd1;
            ram_we_a <= a_found && we_i[a_idx];
            ram_we_b <= b_found && we_i[b_idx];
            if (a_found) begin
                ram_addr_a <= addr_arr[a_idx];
                ram_din_a  <= wdata_arr[a_idx];
            end
            if (b_found) begin
                ram_addr_b <= addr_arr[b_idx];
                ram_din_b  <= wdata_arr[b_idx];
            end
        end
    end

    // Stage 1 tracks the RAM address cycle, stage 2 the RAM data cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_a <= 1'b0;
            s1_vld_b <= 1'b0;
            s1_tag_a <= '0;
            s1_tag_b <= '0;
            s2_vld_a <= 1'b0;
            s2_vld_b <= 1'b0;
            s2_tag_a <= '0;
            s2_tag_b <= '0;
            rvalid_o <= '0;
            for (int i = 0; i < 4; i++) rdata_q[i] <= '0;
        end else begin
            s1_vld_a <= a_found && !we_i[a_idx];
            s1_vld_b <= b_found && !we_i[b_idx];
            s1_tag_a <= a_idx;
            s1_tag_b <= b_idx;
            s2_vld_a <= s1_vld_a;
            s2_vld_b <= s1_vld_b;
            s2_tag_a <= s1_tag_a;
            s2_tag_b <= s1_tag_b;
            rvalid_o <= ({3'b000, s2_vld_a} << s2_tag_a) | ({3'b000, s2_vld_b} << s2_tag_b);
            if (s2_vld_a) rdata_q[s2_tag_a] <= ram_dout_a;
            if (s2_vld_b) rdata_q[s2_tag_b] <= ram_dout_b;
        end
    end

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Directed bench for dpram_port_arbiter: a RAM model on the RAM ports and a
// behavioural arbitration model compared against the DUT on every falling edge.
module tb_dpram_port_arbiter;
    localparam int AW = 4;
    localparam int DW = 8;

    typedef struct {
        int            due;
        int            who;
        logic [DW-1:0] data;
    } rd_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [3:0]      req_i;
    logic [3:0]      we_i;
    logic [4*AW-1:0] addr_i;
    logic [4*DW-1:0] wdata_i;
    logic [3:0]      gnt_o;
    logic [3:0]      rvalid_o;
    logic [4*DW-1:0] rdata_o;
    logic            ram_we_a, ram_we_b;
    logic [AW-1:0]   ram_addr_a, ram_addr_b;
    logic [DW-1:0]   ram_din_a, ram_din_b;
    logic [DW-1:0]   ram_dout_a, ram_dout_b;

    int checks = 0;
    int errors = 0;

    dpram_port_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (req_i),
        .we_i       (we_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .gnt_o      (gnt_o),
        .rvalid_o   (rvalid_o),
        .rdata_o    (rdata_o),
        .ram_we_a   (ram_we_a),
        .ram_addr_a (ram_addr_a),
        .ram_din_a  (ram_din_a),
        .ram_we_b   (ram_we_b),
        .ram_addr_b (ram_addr_b),
        .ram_din_b  (ram_din_b),
        .ram_dout_a (ram_dout_a),
        .ram_dout_b (ram_dout_b)
    );

    always #5 clk = ~clk;

    // Synchronous dual-port RAM, read-old-data, preloaded with addr*0x11.
    logic [DW-1:0] ram [16] = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77,
                                8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
    always @(posedge clk) begin
        if (ram_we_a) ram[ram_addr_a] <= ram_din_a;
        if (ram_we_b) ram[ram_addr_b] <= ram_din_b;
        ram_dout_a <= ram[ram_addr_a];
        ram_dout_b <= ram[ram_addr_b];
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply_stimulus(input logic [3:0] r, input logic [3:0] w,
                                  input logic [4*AW-1:0] a, input logic [4*DW-1:0] d);
        @(posedge clk);
        #1;
        req_i   = r;
        we_i    = w;
        addr_i  = a;
        wdata_i = d;
        #1;
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    function automatic bit clash(input int x, input int y);
        return (addr_i[x*AW +: AW] == addr_i[y*AW +: AW]) && (we_i[x] || we_i[y]);
    endfunction

    // Behavioural model: scan-order list, per-port expectations, delivery queue.
    initial begin : model
        rd_t           pend[$];
        rd_t           keep[$];
        wr_t           pw[$];
        int            order[$];
        logic [DW-1:0] mem_m   [16];
        logic [DW-1:0] last_rd [4];
        int            wait_m  [4];
        logic          exp_we  [2];
        logic [AW-1:0] exp_addr[2];
        logic [DW-1:0] exp_din [2];
        int            sel     [2];
        int            ptr_m, ncyc, a, b, worst;
        logic [3:0]    exp_gnt, exp_rv;

        for (int i = 0; i < 16; i++) mem_m[i] = DW'(i * 17);
        ncyc = 0;
        forever begin
            @(negedge clk);
            ncyc++;
            if (!rst_n) begin
                ptr_m = 0;
                for (int p = 0; p < 2; p++) begin
                    exp_we[p]   = 1'b0;
                    exp_addr[p] = '0;
                    exp_din[p]  = '0;
                end
                for (int i = 0; i < 4; i++) begin
                    last_rd[i] = '0;
                    wait_m[i]  = 0;
                end
                pend.delete();
                pw.delete();
                check_output("reset_outputs",
                             {gnt_o, rvalid_o, ram_we_a, ram_we_b, ram_addr_a, ram_addr_b, ram_din_a, ram_din_b}, '0);
                check_output("reset_rdata", rdata_o, '0);
            end else begin
                foreach (pw[k]) mem_m[pw[k].addr] = pw[k].data;
                pw.delete();

                check_output("ram_port_a", {ram_we_a, ram_addr_a, ram_din_a}, {exp_we[0], exp_addr[0], exp_din[0]});
                check_output("ram_port_b", {ram_we_b, ram_addr_b, ram_din_b}, {exp_we[1], exp_addr[1], exp_din[1]});

                exp_rv = '0;
                keep.delete();
                foreach (pend[k]) begin
                    if (pend[k].due == ncyc) begin
                        exp_rv[pend[k].who]  = 1'b1;
                        last_rd[pend[k].who] = pend[k].data;
                    end else begin
                        keep.push_back(pend[k]);
                    end
                end
                pend = keep;
                check_output("rvalid", rvalid_o, exp_rv);
                check_output("rdata", rdata_o, {last_rd[3], last_rd[2], last_rd[1], last_rd[0]});

                order.delete();
                for (int k = 0; k < 4; k++)
                    if (req_i[(ptr_m + k) % 4]) order.push_back((ptr_m + k) % 4);
                a = -1;
                b = -1;
                if (order.size() > 0) begin
                    a = order[0];
                    for (int j = 1; j < order.size(); j++)
                        if (b < 0 && !clash(a, order[j])) b = order[j];
                end
                exp_gnt = '0;
                if (a >= 0) exp_gnt[a] = 1'b1;
                if (b >= 0) exp_gnt[b] = 1'b1;
                check_output("gnt", gnt_o, exp_gnt);

                sel[0] = a;
                sel[1] = b;
                for (int p = 0; p < 2; p++) begin
                    if (sel[p] >= 0) begin
                        exp_we[p]   = we_i[sel[p]];
                        exp_addr[p] = addr_i[sel[p]*AW +: AW];
                        exp_din[p]  = wdata_i[sel[p]*DW +: DW];
                        if (we_i[sel[p]])
                            pw.push_back('{exp_addr[p], exp_din[p]});
                        else
                            pend.push_back('{ncyc + 3, sel[p], mem_m[exp_addr[p]]});
                    end else begin
                        exp_we[p] = 1'b0;
                    end
                end
                if (b >= 0)
                    ptr_m = (b + 1) % 4;
                else if (a >= 0)
                    ptr_m = (a + 1) % 4;

                worst = 0;
                for (int i = 0; i < 4; i++) begin
                    if (req_i[i] && !exp_gnt[i]) wait_m[i]++;
                    else wait_m[i] = 0;
                    if (wait_m[i] > worst) worst = wait_m[i];
                end
                if (req_i != 4'b0000) check_output("fairness_wait", 64'(worst > 3), '0);
            end
        end
    end

    initial begin : stimulus
        rst_n   = 1'b0;
        req_i   = 4'b1111;
        we_i    = '0;
        addr_i  = '0;
        wdata_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check_output("gnt_in_reset", gnt_o, 4'b0000);
        req_i = '0;
        rst_n = 1'b1;

        // Single write then read-back by another requester.
        apply_stimulus(4'b0001, 4'b0001, 16'h0003, 32'h000000A5);
        check_output("t1_gnt", gnt_o, 4'b0001);
        apply_stimulus(4'b0010, 4'b0000, 16'h0030, '0);
        check_output("t1_ram_a", {ram_we_a, ram_addr_a, ram_din_a}, {1'b1, 4'h3, 8'hA5});
        check_output("t1_ram_we_b", ram_we_b, 1'b0);
        check_output("t2_gnt", gnt_o, 4'b0010);
        apply_stimulus('0, '0, '0, '0);
        wait_edges(2);
        check_output("t2_rvalid", rvalid_o, 4'b0010);
        check_output("t2_rdata1", rdata_o[15:8], 8'hA5);

        // Bring the pointer round to 0, then four full-load read cycles.
        apply_stimulus(4'b1000, 4'b0000, 16'h3000, '0);
        check_output("t3_gnt_ptr", gnt_o, 4'b1000);
        for (int c = 0; c < 4; c++) begin
            apply_stimulus(4'b1111, 4'b0000, 16'hBA98, '0);
            check_output("t3_gnt_rr", gnt_o, (c % 2 == 0) ? 4'b0011 : 4'b1100);
        end
        check_output("t3_rvalid_lo", rvalid_o, 4'b0011);
        check_output("t3_rdata_lo", rdata_o[15:0], 16'h9988);
        apply_stimulus('0, '0, '0, '0);
        check_output("t3_rvalid_hi", rvalid_o, 4'b1100);
        check_output("t3_rdata_hi", rdata_o[31:16], 16'hBBAA);

        // Two writes to one address must serialise.
        apply_stimulus(4'b0011, 4'b0011, 16'h0077, 32'h0000C33C);
        check_output("t4_gnt_first", gnt_o, 4'b0001);
        apply_stimulus(4'b0010, 4'b0010, 16'h0077, 32'h0000C33C);
        check_output("t4_gnt_second", gnt_o, 4'b0010);
        check_output("t4_ram_first", {ram_we_a, ram_addr_a, ram_din_a, ram_we_b}, {1'b1, 4'h7, 8'h3C, 1'b0});
        apply_stimulus('0, '0, '0, '0);
        check_output("t4_ram_second", {ram_we_a, ram_addr_a, ram_din_a, ram_we_b}, {1'b1, 4'h7, 8'hC3, 1'b0});

        // Two reads of one address share the cycle.
        apply_stimulus(4'b0101, 4'b0000, 16'h0202, '0);
        check_output("t5_gnt", gnt_o, 4'b0101);
        apply_stimulus('0, '0, '0, '0);
        wait_edges(2);
        check_output("t5_rvalid", rvalid_o, 4'b0101);
        check_output("t5_rdata", {rdata_o[23:16], rdata_o[7:0]}, 16'h2222);

        // The later of the two writes is the one that sticks.
        apply_stimulus(4'b0001, 4'b0000, 16'h0007, '0);
        check_output("t6_gnt", gnt_o, 4'b0001);
        apply_stimulus('0, '0, '0, '0);
        wait_edges(2);
        check_output("t6_rvalid", rvalid_o, 4'b0001);
        check_output("t6_rdata0", rdata_o[7:0], 8'hC3);

        // Reset in the middle of an in-flight read and a pending write.
        apply_stimulus(4'b0001, 4'b0000, 16'h0008, '0);
        check_output("t7_gnt_read", gnt_o, 4'b0001);
        apply_stimulus(4'b0100, 4'b0100, 16'h0500, 32'h00EE0000);
        check_output("t7_gnt_write", gnt_o, 4'b0100);
        @(posedge clk);
        #1;
        rst_n   = 1'b0;
        req_i   = '0;
        we_i    = '0;
        addr_i  = '0;
        wdata_i = '0;
        #1;
        check_output("t7_reset_we", {ram_we_a, ram_we_b, rvalid_o}, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_edges(1);
        check_output("t7_no_rvalid1", rvalid_o, 4'b0000);
        wait_edges(1);
        check_output("t7_no_rvalid2", {rvalid_o, ram_we_a, ram_we_b}, '0);
        apply_stimulus(4'b1001, 4'b0000, 16'h3005, '0);
        check_output("t7_gnt_after", gnt_o, 4'b1001);
        apply_stimulus('0, '0, '0, '0);
        check_output("t7_ptr_zero", {ram_addr_a, ram_addr_b}, {4'h5, 4'h3});
        wait_edges(2);
        check_output("t7_rvalid", rvalid_o, 4'b1001);
        check_output("t7_rdata", {rdata_o[31:24], rdata_o[7:0]}, {8'hA5, 8'h55});

        wait_edges(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
